// File: rtl/h_counter.sv
// h_counter: horizontal pixel counter for video timing, with hsync, active-video
// and end-of-line strobes decoded from the registered count.
module h_counter #(
   parameter int H_VISIBLE = 800,
   parameter int H_FRONT   = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BACK    = 88,
   parameter bit HSYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] count,
   output logic        hsync,
   output logic        active,
   output logic        line_end
);
   localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   logic [10:0] r_count;
   logic        w_in_sync;
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_count <= '0;
      else      r_count <= (r_count == H_LAST) ? '0 : r_count + 11'd1;
   always_comb begin
      w_in_sync = (r_count >= HS_START) && (r_count < HS_END);
      count     = r_count;
      active    = r_count < H_VIS;
      hsync     = w_in_sync ? HSYNC_POL : ~HSYNC_POL;
      line_end  = r_count == H_LAST;
   end
endmodule

// File: tb/tb_h_counter.sv
// tb_h_counter: checks h_counter against an edges-since-reset model every cycle,
// plus hand-computed literals at the line boundaries and around async reset.
`timescale 1ns/1ps
module tb_h_counter;
   localparam int VIS = 800, FP = 40, SY = 128, BP = 88, TOT = VIS + FP + SY + BP;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] count;
   logic        hsync, active, line_end;
   int          vec = 0, miss = 0;
   int          edges = 0;
   bit          chk_en = 1'b0;

   h_counter dut (.clk(clk), .rst(rst), .count(count), .hsync(hsync), .active(active), .line_end(line_end));

   always #12.5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vec++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the position is simply the number of counted edges modulo the line length.
   always @(posedge clk or negedge rst)
      if (!rst) edges <= 0;
      else      edges <= edges + 1;

   always @(negedge clk)
      if (chk_en) begin
         int c;
         c = edges % TOT;
         chk("model_count", int'(count), c);
         chk("model_active", int'(active), int'(c < VIS));
         chk("model_hsync", int'(hsync), int'(c >= VIS + FP && c < VIS + FP + SY));
         chk("model_line_end", int'(line_end), int'(c == TOT - 1));
      end

   initial begin
      int pulses, first_p, last_p, maxc, n;
      #5;
      chk("rst_count", int'(count), 0);
      chk("rst_active", int'(active), 1);
      chk("rst_hsync", int'(hsync), 0);
      chk("rst_line_end", int'(line_end), 0);
      #5 rst = 1'b1;
      chk_en = 1'b1;
      pulses = 0; first_p = -1; last_p = -1; maxc = 0;
      for (int i = 1; i <= 2 * TOT; i++) begin
         @(negedge clk);
         if (int'(count) > maxc) maxc = int'(count);
         if (line_end) begin
            pulses++;
            if (first_p < 0) first_p = i;
            last_p = i;
         end
         if (i == 1)    chk("first_count", int'(count), 1);
         if (i == 2)    chk("second_count", int'(count), 2);
         if (i == 799)  chk("active_799", int'(active), 1);
         if (i == 800)  chk("active_800", int'(active), 0);
         if (i == 839)  chk("hsync_839", int'(hsync), 0);
         if (i == 840)  chk("hsync_840", int'(hsync), 1);
         if (i == 967)  chk("hsync_967", int'(hsync), 1);
         if (i == 968)  chk("hsync_968", int'(hsync), 0);
         if (i == 1055) chk("line_end_1055", int'(line_end), 1);
         if (i == 1055) chk("count_1055", int'(count), 1055);
         if (i == 1056) chk("wrap_count", int'(count), 0);
         if (i == 1056) chk("wrap_line_end", int'(line_end), 0);
      end
      chk("line_end_pulses", pulses, 2);
      chk("line_end_gap", last_p - first_p, 1056);
      chk("max_count", maxc, 1055);
      n = 0;
      while (count != 11'd500 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_500", int'(count), 500);
      #3 rst = 1'b0;
      #1 chk("async_rst_count", int'(count), 0);
      chk("async_rst_hsync", int'(hsync), 0);
      repeat (2) @(negedge clk);
      chk("held_rst_count", int'(count), 0);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("resume_1", int'(count), 1);
      @(negedge clk);
      chk("resume_2", int'(count), 2);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/h_counter.md
H_COUNTER -- requirements
Module: h_counter

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 800, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 40, front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 128, sync-pulse pixels.
REQ-004 The block SHALL have parameter H_BACK, default 88, back-porch pixels.
REQ-005 The block SHALL have parameter HSYNC_POL, default 1, active level of hsync (1 = active-high).
REQ-006 The block SHALL have port clk, input, 1 bit, pixel clock (40 MHz nominal, 800x600@60 Hz).
REQ-007 The block SHALL have port rst, input, 1 bit, reset; one clock, reset asynchronous and active-low.
REQ-008 The block SHALL have port count, output, 11 bits, current horizontal pixel position.
REQ-009 The block SHALL have port hsync, output, 1 bit, horizontal sync pulse at HSYNC_POL level.
REQ-010 The block SHALL have port active, output, 1 bit, high while count is in the visible region.
REQ-011 The block SHALL have port line_end, output, 1 bit, high for the single cycle where count = H_TOTAL-1.

Function
REQ-012 The block SHALL derive H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 1056).
REQ-013 The block SHALL increment count by 1 on every rising clk edge while rst is high.
REQ-014 The block SHALL wrap count from H_TOTAL-1 (1055) to 0 on the next rising edge, with no extra cycle at 0 or 1055.
REQ-015 The block SHALL keep count in 0..H_TOTAL-1 at all times and never present 1056 or higher.
REQ-016 The block SHALL register count with a period of exactly H_TOTAL clocks.
REQ-017 The block SHALL drive active high iff count < H_VISIBLE (0..799), combinationally from count.
REQ-018 The block SHALL drive hsync at HSYNC_POL iff H_VISIBLE+H_FRONT <= count < H_VISIBLE+H_FRONT+H_SYNC (840..967), otherwise at the inverse level.
REQ-019 The block SHALL derive hsync, active and line_end combinationally from the registered count, so they align with count with zero latency.
REQ-020 The block SHALL drive line_end high only when count = H_TOTAL-1.
REQ-021 The block SHALL declare count 11 bits wide; all comparisons SHALL be unsigned and 11 bits wide.

Reset
REQ-022 The block SHALL force count to 0 immediately when rst goes low, without waiting for a clk edge.
REQ-023 During reset the outputs SHALL be count=0, active=1, line_end=0, and hsync at its inactive level.
REQ-024 The block SHALL hold count at 0 for as long as rst stays low.
REQ-025 On the first rising clk edge after rst goes high, count SHALL become 1.
REQ-026 Reset asserted mid-line (e.g. count=500) SHALL return count to 0 asynchronously, and counting SHALL restart from 0.

Verification
REQ-027 Power-up reset: hold rst low for 10 ns with a 25 ns clock -> count=0, active=1, hsync inactive, line_end=0.
REQ-028 Free run after reset release, 1056 edges -> count steps 1..1055 then 0, each value held for exactly one cycle.
REQ-029 Wrap check: count=1055 -> line_end=1 for one cycle, next edge count=0, line_end=0.
REQ-030 Sync window -> active falls when count goes from 799 to 800; hsync asserts at 840 and deasserts at 968 (128 cycles).
REQ-031 Async reset: drive rst low between clk edges while count=500 -> count=0 before the next edge; after release count resumes 1, 2, ...
REQ-032 Run two full lines (2112 cycles) -> exactly two line_end pulses 1056 cycles apart and count never exceeds 1055.
